// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment bit order is a..g at bits 0..6, active-high (1 = lit).
package seg_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEGS   = 7;
    localparam int unsigned IDX_W  = 2;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Glyphs written g..a, active-high
    localparam logic [SEGS-1:0] CHAR_U = 7'b0111110;
    localparam logic [SEGS-1:0] CHAR_P = 7'b1110011;

    // Pick digit idx's seven segments out of the packed parallel bus
    function automatic logic [SEGS-1:0] digit_segs(
        input logic [DIGITS*SEGS-1:0] bus,
        input logic [IDX_W-1:0]       idx
    );
        logic [SEGS-1:0] segs;
        case (idx)
            2'd0:    segs = bus[0*SEGS +: SEGS];
            2'd1:    segs = bus[1*SEGS +: SEGS];
            2'd2:    segs = bus[2*SEGS +: SEGS];
            2'd3:    segs = bus[3*SEGS +: SEGS];
            default: segs = {SEGS{1'b0}};
        endcase
        return segs;
    endfunction

    // Active-high one-hot digit select for slot idx
    function automatic logic [DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] sel;
        case (idx)
            2'd0:    sel = 4'b0001;
            2'd1:    sel = 4'b0010;
            2'd2:    sel = 4'b0100;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Slot/digit/frame timebase for the display scan: owns the slot counter,
// the digit index and the blink frame counter, and emits the derived strobes.
module scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK        = 1000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             slot_blank,
    output logic [IDX_W-1:0] idx,
    output logic             capture,
    output logic             blink_off
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BF_N  = 2 * BLINK_FRAMES;
    localparam int unsigned BF_W  = (BF_N > 1) ? $clog2(BF_N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [BF_W-1:0]  BF_LAST   = BF_W'(BF_N - 1);
    localparam logic [BF_W-1:0]  BF_HALF   = BF_W'(BLINK_FRAMES);
    localparam logic [BF_W-1:0]  BF_ZERO   = BF_W'(0);
    localparam logic [BF_W-1:0]  BF_ONE    = BF_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BF_W-1:0]  bf_q,  bf_d;
    logic             slot_last_s;
    logic             frame_wrap_s;

    assign slot_last_s  = (cnt_q == CNT_LAST);
    assign frame_wrap_s = enable && slot_last_s && (idx_q == 2'd3);

    // Next-state for the slot counter, digit index and blink frame counter
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        bf_d  = bf_q;
        if (!enable) begin
            // Park the scan at the start of digit 0; blink phase is kept
            cnt_d = CNT_ZERO;
            idx_d = 2'd0;
        end else if (slot_last_s) begin
            cnt_d = CNT_ZERO;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (frame_wrap_s) begin
            if (bf_q == BF_LAST) begin
                bf_d = BF_ZERO;
            end else begin
                bf_d = bf_q + BF_ONE;
            end
        end else begin
            bf_d = bf_q;
        end
    end

    // Timebase state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
            idx_q <= 2'd0;
            bf_q  <= BF_ZERO;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            bf_q  <= bf_d;
        end
    end

    assign slot_blank = (cnt_q < CNT_BLANK);
    assign idx        = idx_q;
    assign capture    = enable && (cnt_q == CNT_ZERO) && (idx_q == 2'd0);
    assign blink_off  = (bf_q >= BF_HALF);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a 4-digit parallel segment bus onto one shared segment
// pin set with one-hot digit selects, ghost blanking, frame snapshots and blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIV            = 50000,
    parameter int unsigned BLANK          = 1000,
    parameter int unsigned BLINK_FRAMES   = 128,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     blink_en,
    input  logic [DIGITS*SEGS-1:0]   seg_in,
    output logic [SEGS-1:0]          seg_out,
    output logic [DIGITS-1:0]        dig_sel,
    output logic                     frame_start
);

    // XOR masks that both define the "off" level and apply pin polarity
    localparam logic [SEGS-1:0]   SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic             slot_blank_s;
    logic [IDX_W-1:0] idx_s;
    logic             capture_s;
    logic             blink_off_s;

    logic [DIGITS*SEGS-1:0] snap_q, snap_d;
    logic [SEGS-1:0]        seg_lit_s;
    logic [DIGITS-1:0]      dig_lit_s;
    logic [SEGS-1:0]        seg_out_q, seg_out_d;
    logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
    logic                   frame_start_q, frame_start_d;

    scan_timer #(
        .DIV          (DIV),
        .BLANK        (BLANK),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_scan_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .slot_blank (slot_blank_s),
        .idx        (idx_s),
        .capture    (capture_s),
        .blink_off  (blink_off_s)
    );

    // Frame snapshot: the bus is only sampled at the start of digit 0's slot
    always_comb begin
        if (capture_s) begin
            snap_d = seg_in;
        end else begin
            snap_d = snap_q;
        end
    end

    // Active-high pin image for the current slot, then polarity applied
    always_comb begin
        seg_lit_s = 7'h00;
        dig_lit_s = 4'h0;
        if (enable && !slot_blank_s) begin
            dig_lit_s = digit_onehot(idx_s);
            if (blink_en && blink_off_s) begin
                seg_lit_s = 7'h00;
            end else begin
                seg_lit_s = digit_segs(snap_q, idx_s);
            end
        end else begin
            seg_lit_s = 7'h00;
            dig_lit_s = 4'h0;
        end
        seg_out_d     = seg_lit_s ^ SEG_OFF;
        dig_sel_d     = dig_lit_s ^ DIG_OFF;
        frame_start_d = capture_s;
    end

    // Snapshot and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q        <= {(DIGITS*SEGS){1'b0}};
            seg_out_q     <= SEG_OFF;
            dig_sel_q     <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            snap_q        <= snap_d;
            seg_out_q     <= seg_out_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign dig_sel     = dig_sel_q;
    assign frame_start = frame_start_q;

endmodule
